// File: rtl/auto_jogador_pkg.sv
// auto_jogador_pkg: shared state codes and helpers for the automatic player.
// Holds the FSM encoding, the "no error" sentinel and the move-corruption helper.
package auto_jogador_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PULSO   = 4'd1,
    ESPERA  = 4'd2,
    APLICA  = 4'd3,
    FIM     = 4'd4
  } estado_t;

  // Move index that can never be reached, so no move is corrupted.
  localparam int unsigned ERRO_NENHUM = 16;

  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/rom_jogadas_16x4.sv
// rom_jogadas_16x4: fixed 16-entry one-hot move table.
// Ports: endereco_i (4-bit move index), jogada_o (4-bit one-hot move).
module rom_jogadas_16x4 (
  input  logic [3:0] endereco_i,
  output logic [3:0] jogada_o
);

  always_comb begin
    jogada_o = 4'b0000;
    case (endereco_i)
      4'd0:  jogada_o = 4'b0001;
      4'd1:  jogada_o = 4'b0010;
      4'd2:  jogada_o = 4'b0100;
      4'd3:  jogada_o = 4'b1000;
      4'd4:  jogada_o = 4'b0100;
      4'd5:  jogada_o = 4'b0010;
      4'd6:  jogada_o = 4'b0001;
      4'd7:  jogada_o = 4'b0001;
      4'd8:  jogada_o = 4'b0010;
      4'd9:  jogada_o = 4'b0010;
      4'd10: jogada_o = 4'b0100;
      4'd11: jogada_o = 4'b0100;
      4'd12: jogada_o = 4'b1000;
      4'd13: jogada_o = 4'b1000;
      4'd14: jogada_o = 4'b0001;
      4'd15: jogada_o = 4'b0010;
      default: jogada_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/auto_jogador.sv
// auto_jogador: self-test player that drives the memory game with a fixed
// move sequence and latches the game's verdict.
// Ports: clock, reset (async, high); iniciar_auto start request;
//   pronto/acertou/errou_jogo from the game; iniciar_jogo, chaves to the game;
//   ocupado, fim, resultado_acertou/errou status; db_estado, db_indice debug.
module auto_jogador
  import auto_jogador_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 5,
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned GAP_CYCLES  = 10,
  parameter int unsigned NUM_JOGADAS = 16,
  parameter int unsigned ERRO_POS    = ERRO_NENHUM
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_auto,
  input  logic       pronto_jogo,
  input  logic       acertou_jogo,
  input  logic       errou_jogo,
  output logic       iniciar_jogo,
  output logic [3:0] chaves,
  output logic       ocupado,
  output logic       fim,
  output logic       resultado_acertou,
  output logic       resultado_errou,
  output logic [3:0] db_estado,
  output logic [4:0] db_indice
);

  localparam int unsigned MAX_IH =
    (INIT_CYCLES > HOLD_CYCLES) ? INIT_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_N =
    (MAX_IH > GAP_CYCLES) ? MAX_IH : GAP_CYCLES;
  localparam int CW = $clog2(MAX_N) + 1;

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [4:0]    IDX_FIM   = 5'(NUM_JOGADAS);
  localparam logic [4:0]    IDX_ERRO  = 5'(ERRO_POS);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cont_q, cont_d;
  logic [4:0]    indice_q, indice_d;
  logic          acertou_q, acertou_d;
  logic          errou_q, errou_d;

  logic [3:0] jogada_rom;
  logic [3:0] jogada;

  rom_jogadas_16x4 u_rom (
    .endereco_i (indice_q[3:0]),
    .jogada_o   (jogada_rom)
  );

  assign jogada = (indice_q == IDX_ERRO) ? rotl1(jogada_rom)
                                         : jogada_rom;

  always_comb begin
    estado_d  = estado_q;
    cont_d    = cont_q + 1'b1;
    indice_d  = indice_q;
    acertou_d = acertou_q;
    errou_d   = errou_q;

    if (ocupado && pronto_jogo) begin
      acertou_d = acertou_jogo;
      errou_d   = errou_jogo;
    end

    unique case (estado_q)
      INICIAL, FIM: begin
        cont_d = '0;
        // A restart overrides any verdict still being presented.
        if (iniciar_auto) begin
          estado_d  = PULSO;
          indice_d  = '0;
          acertou_d = 1'b0;
          errou_d   = 1'b0;
        end
      end
      PULSO: begin
        if (cont_q == INIT_LAST) begin
          estado_d = ESPERA;
          cont_d   = '0;
        end
      end
      ESPERA: begin
        if (pronto_jogo) begin
          estado_d = FIM;
          cont_d   = '0;
        end else if (cont_q == GAP_LAST) begin
          estado_d = (indice_q == IDX_FIM) ? FIM : APLICA;
          cont_d   = '0;
        end
      end
      APLICA: begin
        // Abort has priority: the index stays on the aborted move.
        if (pronto_jogo) begin
          estado_d = FIM;
          cont_d   = '0;
        end else if (cont_q == HOLD_LAST) begin
          estado_d = ESPERA;
          cont_d   = '0;
          indice_d = indice_q + 5'd1;
        end
      end
      default: begin
        estado_d = INICIAL;
        cont_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= INICIAL;
      cont_q    <= '0;
      indice_q  <= '0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      indice_q  <= indice_d;
      acertou_q <= acertou_d;
      errou_q   <= errou_d;
    end
  end

  assign ocupado           = (estado_q == PULSO) ||
                             (estado_q == ESPERA) ||
                             (estado_q == APLICA);
  assign iniciar_jogo      = (estado_q == PULSO);
  assign fim               = (estado_q == FIM);
  assign chaves            = (estado_q == APLICA) ? jogada : 4'b0000;
  assign resultado_acertou = acertou_q;
  assign resultado_errou   = errou_q;
  assign db_estado         = estado_q;
  assign db_indice         = indice_q;

endmodule

// File: tb/tb_auto_jogador.sv
// tb_auto_jogador: directed bench with a game model and a move scoreboard.
// Drives two players (defaults, and one corrupting move 15).
module tb_auto_jogador;

  logic clock = 1'b0;
  logic reset;
  logic ini1, ini2, sel;
  logic g_pronto, g_acertou, g_errou;

  logic       ij1, oc1, fim1, ra1, re1;
  logic [3:0] ch1, est1;
  logic [4:0] idx1;
  logic       ij2, oc2, fim2, ra2, re2;
  logic [3:0] ch2, est2;
  logic [4:0] idx2;

  always #5 clock = ~clock;

  auto_jogador dut1 (
    .clock             (clock),
    .reset             (reset),
    .iniciar_auto      (ini1),
    .pronto_jogo       (g_pronto & ~sel),
    .acertou_jogo      (g_acertou & ~sel),
    .errou_jogo        (g_errou & ~sel),
    .iniciar_jogo      (ij1),
    .chaves            (ch1),
    .ocupado           (oc1),
    .fim               (fim1),
    .resultado_acertou (ra1),
    .resultado_errou   (re1),
    .db_estado         (est1),
    .db_indice         (idx1)
  );

  auto_jogador #(.ERRO_POS(15)) dut2 (
    .clock             (clock),
    .reset             (reset),
    .iniciar_auto      (ini2),
    .pronto_jogo       (g_pronto & sel),
    .acertou_jogo      (g_acertou & sel),
    .errou_jogo        (g_errou & sel),
    .iniciar_jogo      (ij2),
    .chaves            (ch2),
    .ocupado           (oc2),
    .fim               (fim2),
    .resultado_acertou (ra2),
    .resultado_errou   (re2),
    .db_estado         (est2),
    .db_indice         (idx2)
  );

  logic [3:0] gold [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b0001, 4'b0010
  };

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int g_step = 0;
  int abort_at = -1;
  int fim_c;
  logic [3:0] prev = 4'b0000;
  logic [3:0] exp_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge, run the game model, then
  // score any move that just appeared on chaves.
  task automatic tick();
    logic [3:0] cur;
    logic       ij;
    logic [3:0] e;
    @(negedge clock);
    cyc++;
    cur = sel ? ch2 : ch1;
    ij  = sel ? ij2 : ij1;
    if (reset || ij) begin
      g_pronto  = 1'b0;
      g_acertou = 1'b0;
      g_errou   = 1'b0;
      g_step    = 0;
    end else if (!g_pronto) begin
      if (prev == 4'b0000 && cur != 4'b0000) begin
        if (g_step == abort_at || g_step > 15) begin
          g_pronto = 1'b1;
          g_errou  = 1'b1;
        end else if (cur != gold[g_step]) begin
          g_pronto = 1'b1;
          g_errou  = 1'b1;
        end else begin
          g_step++;
        end
      end else if (prev != 4'b0000 && cur == 4'b0000 && g_step == 16) begin
        g_pronto  = 1'b1;
        g_acertou = 1'b1;
      end
    end
    if (prev == 4'b0000 && cur != 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_move", 32'(cur), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_move", 32'(cur), 32'(e));
      end
    end
    prev = cur;
  endtask

  task automatic start1();
    ini1 = 1'b1;
    tick();
    ini1 = 1'b0;
    cyc = 0;
  endtask

  task automatic start2();
    ini2 = 1'b1;
    tick();
    ini2 = 1'b0;
    cyc = 0;
  endtask

  initial begin
    reset = 1'b1;
    ini1 = 1'b0;
    ini2 = 1'b0;
    sel = 1'b0;
    g_pronto = 1'b0;
    g_acertou = 1'b0;
    g_errou = 1'b0;

    // Reset and idle
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_chaves", 32'(ch1), 32'd0);
    chk("rst_iniciar", 32'(ij1), 32'd0);
    chk("rst_ocupado", 32'(oc1), 32'd0);
    chk("rst_fim", 32'(fim1), 32'd0);
    chk("rst_res_acertou", 32'(ra1), 32'd0);
    chk("rst_res_errou", 32'(re1), 32'd0);
    chk("rst_estado", 32'(est1), 32'd0);
    chk("rst_indice", 32'(idx1), 32'd0);
    chk("rst2_estado", 32'(est2), 32'd0);

    // Timing of the first moves, then full correct run
    for (int i = 0; i < 16; i++) exp_q.push_back(gold[i]);
    start1();
    while (cyc <= 40) begin
      chk("iniciar_pulse", 32'(ij1), (cyc < 5) ? 32'd1 : 32'd0);
      chk("chaves_timing", 32'(ch1),
          (cyc >= 15 && cyc < 25) ? 32'd1 :
          (cyc >= 35 && cyc < 45) ? 32'd2 : 32'd0);
      tick();
    end
    while (!fim1 && cyc < 400) tick();
    fim_c = fim1 ? cyc : -1;
    chk("full_fim_cycle", 32'(fim_c), 32'd326);
    chk("full_res_acertou", 32'(ra1), 32'd1);
    chk("full_res_errou", 32'(re1), 32'd0);
    chk("full_indice", 32'(idx1), 32'd16);
    chk("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Error-injecting instance
    sel = 1'b1;
    prev = 4'b0000;
    for (int i = 0; i < 15; i++) exp_q.push_back(gold[i]);
    exp_q.push_back(4'b0100);
    start2();
    while (!fim2 && cyc < 400) tick();
    fim_c = fim2 ? cyc : -1;
    chk("err_fim_cycle", 32'(fim_c), 32'd316);
    chk("err_res_errou", 32'(re2), 32'd1);
    chk("err_res_acertou", 32'(ra2), 32'd0);
    chk("err_indice", 32'(idx2), 32'd15);
    chk("err_chaves", 32'(ch2), 32'd0);
    chk("err_sb_empty", 32'(exp_q.size()), 32'd0);

    // Restart while the game still presents pronto, then abort on move 3
    sel = 1'b0;
    prev = 4'b0000;
    abort_at = 3;
    for (int i = 0; i < 4; i++) exp_q.push_back(gold[i]);
    start1();
    chk("restart_estado", 32'(est1), 32'd1);
    chk("restart_res_acertou", 32'(ra1), 32'd0);
    chk("restart_res_errou", 32'(re1), 32'd0);
    chk("restart_indice", 32'(idx1), 32'd0);
    while (!fim1 && cyc < 400) tick();
    fim_c = fim1 ? cyc : -1;
    chk("abort_fim_cycle", 32'(fim_c), 32'd76);
    chk("abort_chaves", 32'(ch1), 32'd0);
    chk("abort_indice", 32'(idx1), 32'd3);
    chk("abort_res_errou", 32'(re1), 32'd1);
    chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);

    // Second restart from move 0, then asynchronous reset mid-move
    abort_at = -1;
    exp_q.push_back(gold[0]);
    start1();
    chk("restart2_estado", 32'(est1), 32'd1);
    chk("restart2_res_errou", 32'(re1), 32'd0);
    chk("restart2_indice", 32'(idx1), 32'd0);
    while (cyc < 17) tick();
    chk("restart2_move0", 32'(ch1), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_chaves", 32'(ch1), 32'd0);
    chk("async_estado", 32'(est1), 32'd0);
    chk("async_ocupado", 32'(oc1), 32'd0);
    chk("async_indice", 32'(idx1), 32'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();

    // Start request during ESPERA is ignored
    exp_q.push_back(gold[0]);
    exp_q.push_back(gold[1]);
    start1();
    while (cyc < 27) tick();
    chk("ign_estado_before", 32'(est1), 32'd2);
    chk("ign_indice_before", 32'(idx1), 32'd1);
    ini1 = 1'b1;
    tick();
    ini1 = 1'b0;
    chk("ign_estado_after", 32'(est1), 32'd2);
    chk("ign_indice_after", 32'(idx1), 32'd1);
    while (cyc < 34) tick();
    chk("ign_gap_end", 32'(ch1), 32'd0);
    tick();
    chk("ign_move1_on_time", 32'(ch1), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
